// File: rtl/qsn_ctrl_pkg.sv
// Shared constants, FSM state type and shift-decode helpers for the QSN shift scheduler.
package qsn_ctrl_pkg;

  localparam int unsigned ZDef      = 17;
  localparam int unsigned SelWDef   = 5;
  localparam int unsigned TagWDef   = 4;
  localparam int unsigned QsnLatDef = 1;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Merge mask for a reduced shift s (s < z): low z-s bits set, upper s bits clear.
  function automatic logic [31:0] shift_to_mask(input int unsigned s, input int unsigned z);
    return (32'd1 << (z - s)) - 32'd1;
  endfunction

  // Right shifter rotates the other way: z-s, with s=0 mapping to 0 rather than z.
  function automatic int unsigned shift_to_right_sel(input int unsigned s, input int unsigned z);
    return (s == 0) ? 0 : (z - s);
  endfunction

endpackage

// File: rtl/qsn_rr_arb2.sv
// Two-requester round-robin arbiter. The pointer side wins a tie; the pointer moves to the
// other side whenever a grant is issued (grants only go to valid requesters).
module qsn_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  // Grant decode and pointer update.
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = ptr_q ? 2'b10 : 2'b01;
      end else begin
        gnt_o = req_i;
      end
    end
    if (gnt_o != 2'b00) begin
      ptr_d = gnt_o[0];
    end
  end

  // Pointer register, reset favours requester 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/qsn_shift_ctrl.sv
// Scheduler for a shared QSN cyclic-shift datapath: round-robin grant, shift decode,
// mask/tag/src alignment with the shifter latency and layer-boundary drain.
// Optional macro QSN_SHIFT_STATS_EN adds per-side accepted-request counters.
module qsn_shift_ctrl
  import qsn_ctrl_pkg::*;
#(
  parameter int unsigned Z       = ZDef,
  parameter int unsigned SEL_W   = SelWDef,
  parameter int unsigned QSN_LAT = QsnLatDef,
  parameter int unsigned TAG_W   = TagWDef
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [SEL_W-1:0] req0_shift,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [SEL_W-1:0] req1_shift,
  input  logic [TAG_W-1:0] req1_tag,
  input  logic             hold,
  input  logic             layer_end,
  output logic             qsn_issue,
  output logic             qsn_src,
  output logic [SEL_W-1:0] qsn_left_sel,
  output logic [SEL_W-1:0] qsn_right_sel,
  output logic             out_valid,
  output logic [Z-1:0]     out_merge_mask,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_src,
  output logic             drain_done,
  output logic             err_shift
`ifdef QSN_SHIFT_STATS_EN
  ,
  output logic [15:0]      stat_cnt0,
  output logic [15:0]      stat_cnt1
`endif
);

  state_e state_q, state_d;

  logic [1:0]       gnt;
  logic             arb_en, xfer, busy;
  logic [SEL_W-1:0] shift_raw, shift_red;
  logic [TAG_W-1:0] tag_raw;

  logic             issue_q, issue_d, src_q, src_d, err_q, err_d;
  logic [SEL_W-1:0] left_q, left_d, right_q, right_d;
  logic [Z-1:0]     mask_q, mask_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [QSN_LAT-1:0] pipe_valid_q, pipe_valid_d, pipe_src_q, pipe_src_d;
  logic [Z-1:0]       pipe_mask_q [QSN_LAT];
  logic [Z-1:0]       pipe_mask_d [QSN_LAT];
  logic [TAG_W-1:0]   pipe_tag_q  [QSN_LAT];
  logic [TAG_W-1:0]   pipe_tag_d  [QSN_LAT];

  // Readys are forced low while reset is held so every output reads 0 during reset.
  assign arb_en = (state_q == StRun) && !hold && !rst;

  qsn_rr_arb2 u_arb (
    .clk_i (sys_clk),
    .rst_i (rst),
    .en_i  (arb_en),
    .req_i ({req1_valid, req0_valid}),
    .gnt_o (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign xfer       = |gnt;
  assign shift_raw  = gnt[1] ? req1_shift : req0_shift;
  assign tag_raw    = gnt[1] ? req1_tag : req0_tag;
  assign shift_red  = (shift_raw >= SEL_W'(Z)) ? shift_raw - SEL_W'(Z) : shift_raw;

  // Issue stage: decode the granted shift; selects hold their value on idle cycles.
  always_comb begin
    issue_d = xfer;
    src_d   = src_q;
    left_d  = left_q;
    right_d = right_q;
    mask_d  = mask_q;
    tag_d   = tag_q;
    err_d   = err_q;
    if (xfer) begin
      src_d   = gnt[1];
      left_d  = shift_red;
      right_d = SEL_W'(shift_to_right_sel(32'(shift_red), Z));
      mask_d  = Z'(shift_to_mask(32'(shift_red), Z));
      tag_d   = tag_raw;
      if (shift_raw >= SEL_W'(Z)) begin
        err_d = 1'b1;
      end
    end
  end

  // Alignment chain: follows the shifter's internal register stages one for one.
  always_comb begin
    pipe_valid_d  = {pipe_valid_q[QSN_LAT-1:0], issue_q} >> 0;
    pipe_valid_d[0] = issue_q;
    pipe_src_d[0]   = src_q;
    pipe_mask_d[0]  = mask_q;
    pipe_tag_d[0]   = tag_q;
    for (int i = 1; i < int'(QSN_LAT); i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_src_d[i]   = pipe_src_q[i-1];
      pipe_mask_d[i]  = pipe_mask_q[i-1];
      pipe_tag_d[i]   = pipe_tag_q[i-1];
    end
  end

  // Drain FSM: busy ignores the final stage, so DONE lands the cycle after the last result.
  always_comb begin
    state_d = state_q;
    busy    = issue_q;
    for (int i = 0; i + 1 < int'(QSN_LAT); i++) begin
      busy = busy | pipe_valid_q[i];
    end
    unique case (state_q)
      StRun:   if (layer_end) state_d = StDrain;
      StDrain: if (!busy) state_d = StDone;
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // State, issue-stage and alignment registers; reset drops everything in flight.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q      <= StRun;
      issue_q      <= 1'b0;
      src_q        <= 1'b0;
      left_q       <= '0;
      right_q      <= '0;
      mask_q       <= '0;
      tag_q        <= '0;
      err_q        <= 1'b0;
      pipe_valid_q <= '0;
      pipe_src_q   <= '0;
      for (int i = 0; i < int'(QSN_LAT); i++) begin
        pipe_mask_q[i] <= '0;
        pipe_tag_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      issue_q      <= issue_d;
      src_q        <= src_d;
      left_q       <= left_d;
      right_q      <= right_d;
      mask_q       <= mask_d;
      tag_q        <= tag_d;
      err_q        <= err_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_src_q   <= pipe_src_d;
      for (int i = 0; i < int'(QSN_LAT); i++) begin
        pipe_mask_q[i] <= pipe_mask_d[i];
        pipe_tag_q[i]  <= pipe_tag_d[i];
      end
    end
  end

  assign qsn_issue      = issue_q;
  assign qsn_src        = src_q;
  assign qsn_left_sel   = left_q;
  assign qsn_right_sel  = right_q;
  assign out_valid      = pipe_valid_q[QSN_LAT-1];
  assign out_src        = pipe_src_q[QSN_LAT-1];
  assign out_merge_mask = pipe_mask_q[QSN_LAT-1];
  assign out_tag        = pipe_tag_q[QSN_LAT-1];
  assign drain_done     = (state_q == StDone);
  assign err_shift      = err_q;

`ifdef QSN_SHIFT_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Saturating per-side accept counters, cleared at each drain completion.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (state_q == StDone) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (gnt[0] && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
      if (gnt[1] && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign stat_cnt0 = cnt0_q;
  assign stat_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_qsn_shift_ctrl.sv
// Self-checking bench for qsn_shift_ctrl: directed scenarios plus a randomized run, with a
// cycle-indexed reference model of grants, issue/output timing, drain and error flag.
module tb_qsn_shift_ctrl;

  localparam int Z = 17;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0, hold = 0, layer_end = 0;
  logic [4:0]  req0_shift = 0, req1_shift = 0;
  logic [3:0]  req0_tag = 0, req1_tag = 0;
  logic        req0_ready, req1_ready, qsn_issue, qsn_src, out_valid, out_src;
  logic        drain_done, err_shift;
  logic [4:0]  qsn_left_sel, qsn_right_sel;
  logic [16:0] out_merge_mask;
  logic [3:0]  out_tag;
`ifdef QSN_SHIFT_STATS_EN
  logic [15:0] stat_cnt0, stat_cnt1;
`endif

  qsn_shift_ctrl dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .req0_valid     (req0_valid),
    .req0_ready     (req0_ready),
    .req0_shift     (req0_shift),
    .req0_tag       (req0_tag),
    .req1_valid     (req1_valid),
    .req1_ready     (req1_ready),
    .req1_shift     (req1_shift),
    .req1_tag       (req1_tag),
    .hold           (hold),
    .layer_end      (layer_end),
    .qsn_issue      (qsn_issue),
    .qsn_src        (qsn_src),
    .qsn_left_sel   (qsn_left_sel),
    .qsn_right_sel  (qsn_right_sel),
    .out_valid      (out_valid),
    .out_merge_mask (out_merge_mask),
    .out_tag        (out_tag),
    .out_src        (out_src),
    .drain_done     (drain_done),
    .err_shift      (err_shift)
`ifdef QSN_SHIFT_STATS_EN
    ,
    .stat_cnt0      (stat_cnt0),
    .stat_cnt1      (stat_cnt1)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          src;
    int          left;
    int          right;
    logic [16:0] mask;
    logic [3:0]  tag;
  } exp_t;

  // Reference model state, all keyed by the cycle index cyc.
  bit   sb_en = 0;
  int   cyc = 0;
  bit   m_ptr;
  int   le_cyc, done_cyc, last_out, err_cyc, last_left, last_right;
  exp_t iss_m[int];
  exp_t out_m[int];

  task automatic sb_reset();
    m_ptr = 0; le_cyc = -1; done_cyc = -1; last_out = -1; err_cyc = -1;
    last_left = 0; last_right = 0;
    iss_m.delete();
    out_m.delete();
  endtask

  // Scoreboard: one evaluation per cycle, sampled on the falling edge.
  always @(negedge sys_clk) begin : sb
    bit   in_drain, g0, g1, exp_done, exp_err;
    int   s;
    exp_t e;
    if (sb_en) begin
      in_drain = (cyc > le_cyc) && (cyc <= done_cyc);
      g0 = 0; g1 = 0;
      if (!in_drain && !hold) begin
        if (req0_valid && req1_valid) begin
          g0 = (m_ptr == 0); g1 = (m_ptr == 1);
        end else begin
          g0 = req0_valid; g1 = req1_valid;
        end
      end
      checks++;
      if (req0_ready !== g0 || req1_ready !== g1) begin
        failures++;
        $display("FAIL sb_ready cyc=%0d got=%b%b exp=%b%b", cyc, req1_ready, req0_ready, g1, g0);
      end
      if (g0 || g1) begin
        s = g1 ? int'(req1_shift) : int'(req0_shift);
        if (s >= Z) begin
          s -= Z;
          if (err_cyc < 0) err_cyc = cyc + 1;
        end
        e.src = g1; e.left = s; e.right = (s == 0) ? 0 : Z - s;
        e.mask = '0;
        for (int b = 0; b < Z - s; b++) e.mask[b] = 1'b1;
        e.tag = g1 ? req1_tag : req0_tag;
        iss_m[cyc+1] = e;
        out_m[cyc+2] = e;
        last_out = cyc + 2;
        m_ptr = g0;
      end
      checks++;
      if (iss_m.exists(cyc)) begin
        e = iss_m[cyc];
        if (qsn_issue !== 1'b1 || qsn_src !== e.src || int'(qsn_left_sel) != e.left ||
            int'(qsn_right_sel) != e.right) begin
          failures++;
          $display("FAIL sb_issue cyc=%0d got=%b/%b/%0d/%0d exp=1/%b/%0d/%0d", cyc, qsn_issue,
                   qsn_src, qsn_left_sel, qsn_right_sel, e.src, e.left, e.right);
        end
        last_left = e.left; last_right = e.right;
        iss_m.delete(cyc);
      end else if (qsn_issue !== 1'b0 || int'(qsn_left_sel) != last_left ||
                   int'(qsn_right_sel) != last_right) begin
        failures++;
        $display("FAIL sb_idle cyc=%0d got=%b/%0d/%0d exp=0/%0d/%0d", cyc, qsn_issue,
                 qsn_left_sel, qsn_right_sel, last_left, last_right);
      end
      checks++;
      if (out_m.exists(cyc)) begin
        e = out_m[cyc];
        if (out_valid !== 1'b1 || out_src !== e.src || out_merge_mask !== e.mask ||
            out_tag !== e.tag) begin
          failures++;
          $display("FAIL sb_out cyc=%0d got=%b/%b/%h/%h exp=1/%b/%h/%h", cyc, out_valid, out_src,
                   out_merge_mask, out_tag, e.src, e.mask, e.tag);
        end
        out_m.delete(cyc);
      end else if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL sb_out_idle cyc=%0d got=%b exp=0", cyc, out_valid);
      end
      if (!in_drain && layer_end) begin
        le_cyc = cyc;
        done_cyc = (last_out + 1 > cyc + 2) ? last_out + 1 : cyc + 2;
      end
      exp_done = (cyc == done_cyc);
      exp_err  = (err_cyc >= 0) && (cyc >= err_cyc);
      checks++;
      if (drain_done !== exp_done || err_shift !== exp_err) begin
        failures++;
        $display("FAIL sb_flags cyc=%0d got=%b/%b exp=%b/%b", cyc, drain_done, err_shift,
                 exp_done, exp_err);
      end
      cyc++;
    end
  end

  task automatic drive(input bit v0, input int s0, input int t0, input bit v1, input int s1,
                       input int t1, input bit h, input bit le);
    req0_valid = v0; req0_shift = 5'(s0); req0_tag = 4'(t0);
    req1_valid = v1; req1_shift = 5'(s1); req1_tag = 4'(t1);
    hold = h; layer_end = le;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 5, 1, 1, 6, 2, 0, 0);
    #2;
    checks++;
    if ({req0_ready, req1_ready, qsn_issue, qsn_src, out_valid, out_src, drain_done,
         err_shift} !== 8'b0 || qsn_left_sel !== 5'd0 || qsn_right_sel !== 5'd0 ||
        out_merge_mask !== 17'd0 || out_tag !== 4'd0) begin
      failures++;
      $display("FAIL reset_state got=%b%b%b%b%b%b%b%b exp=00000000", req0_ready, req1_ready,
               qsn_issue, qsn_src, out_valid, out_src, drain_done, err_shift);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 0;
    sb_reset();
    sb_en = 1;
  endtask

  task automatic test_single();
    drive(1, 5, 3, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge sys_clk);
    checks++;
    if (qsn_issue !== 1'b1 || qsn_left_sel !== 5'd5 || qsn_right_sel !== 5'd12 ||
        qsn_src !== 1'b0) begin
      failures++;
      $display("FAIL single_issue got=%b/%0d/%0d/%b exp=1/5/12/0", qsn_issue, qsn_left_sel,
               qsn_right_sel, qsn_src);
    end
    tick();
    @(negedge sys_clk);
    checks++;
    if (out_valid !== 1'b1 || out_merge_mask !== 17'h00FFF || out_tag !== 4'd3) begin
      failures++;
      $display("FAIL single_out got=%b/%h/%h exp=1/00fff/3", out_valid, out_merge_mask, out_tag);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit g[8];
    for (int i = 0; i < 8; i++) begin
      if (i < 6) drive(1, i, i, 1, i + 7, i + 8, 0, 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge sys_clk);
      if (i < 6) begin
        g[i] = req1_ready;
        checks++;
        if ((req0_ready ^ req1_ready) !== 1'b1 || (i > 0 && g[i] == g[i-1])) begin
          failures++;
          $display("FAIL alt_grant i=%0d got=%b%b exp=one-hot alternating", i, req1_ready,
                   req0_ready);
        end
      end
      if (i >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_src !== g[i-2]) begin
          failures++;
          $display("FAIL alt_out i=%0d got=%b/%b exp=1/%b", i, out_valid, out_src, g[i-2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_boundaries();
    int          sh[3] = '{0, 16, 20};
    int          rs[3] = '{0, 1, 14};
    logic [16:0] mk[3] = '{17'h1FFFF, 17'h00001, 17'h03FFF};
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1, sh[k], k + 8, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge sys_clk);
      checks++;
      if (int'(qsn_right_sel) != rs[k]) begin
        failures++;
        $display("FAIL bound_rsel shift=%0d got=%0d exp=%0d", sh[k], qsn_right_sel, rs[k]);
      end
      tick();
      @(negedge sys_clk);
      checks++;
      if (out_valid !== 1'b1 || out_merge_mask !== mk[k] || int'(out_tag) != k + 8) begin
        failures++;
        $display("FAIL bound_mask shift=%0d got=%b/%h exp=1/%h", sh[k], out_valid,
                 out_merge_mask, mk[k]);
      end
      tick();
    end
    @(negedge sys_clk);
    checks++;
    if (err_shift !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got=%b exp=1", err_shift);
    end
    tick();
  endtask

  task automatic test_hold();
    drive(1, 7, 4, 1, 9, 5, 0, 0);
    tick();
    drive(1, 7, 4, 1, 9, 5, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || qsn_issue !== (i == 0) ||
          out_valid !== (i == 1)) begin
        failures++;
        $display("FAIL hold i=%0d got=%b%b/%b/%b exp=00/%b/%b", i, req1_ready, req0_ready,
                 qsn_issue, out_valid, i == 0, i == 1);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_layer_end();
    drive(1, 1, 1, 1, 2, 2, 0, 0);
    tick();
    drive(1, 3, 3, 1, 4, 4, 0, 1);
    @(negedge sys_clk);
    checks++;
    if ((req0_ready ^ req1_ready) !== 1'b1) begin
      failures++;
      $display("FAIL le_same_cycle got=%b%b exp=one-hot", req1_ready, req0_ready);
    end
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5, 5, 1, 6, 6, 0, i == 2);
      @(negedge sys_clk);
      checks++;
      if (drain_done !== (i == 3) || out_valid !== (i == 1 || i == 2) ||
          (req0_ready | req1_ready) !== (i == 4)) begin
        failures++;
        $display("FAIL drain i=%0d got=%b/%b/%b%b exp=%b/%b/%b", i, drain_done, out_valid,
                 req1_ready, req0_ready, i == 3, i == 1 || i == 2, i == 4);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 15),
            $urandom_range(0, 2) != 0, $urandom_range(0, 31), $urandom_range(0, 15),
            $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_reset_midflight();
    drive(1, 2, 6, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sb_en = 0;
    #1;
    rst = 1;
    #1;
    checks++;
    if ({qsn_issue, out_valid, drain_done, err_shift} !== 4'b0 || qsn_left_sel !== 5'd0 ||
        qsn_right_sel !== 5'd0 || out_merge_mask !== 17'd0) begin
      failures++;
      $display("FAIL rst_async got=%b%b%b%b/%0d exp=0000/0", qsn_issue, out_valid, drain_done,
               err_shift, qsn_left_sel);
    end
    tick();
    rst = 0;
    sb_reset();
    sb_en = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      checks++;
      if (out_valid !== 1'b0 || qsn_issue !== 1'b0) begin
        failures++;
        $display("FAIL rst_no_out i=%0d got=%b/%b exp=0/0", i, out_valid, qsn_issue);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_boundaries();
    test_hold();
    test_layer_end();
    test_random();
    test_reset_midflight();
    test_random();
    sb_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
